// File: rtl/f1_start_ctrl.sv
// F1 start-light sequencer: light-advance tick, pseudo-random lights-out delay,
// and driver reaction-time measurement with jump-start detection.
module f1_start_ctrl #(
    parameter int unsigned TICK_N    = 24,
    parameter int unsigned DELAY_MIN = 16,
    parameter logic [6:0]  LFSR_SEED = 7'h01,
    parameter int unsigned REACT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_seq,
    input  logic               cmd_delay,
    input  logic               button,
    output logic               tick,
    output logic               time_out,
    output logic               jump_start,
    output logic               react_valid,
    output logic [REACT_W-1:0] react_time
);

    localparam int unsigned CNT_W  = $clog2(TICK_N);
    localparam int unsigned DCNT_W = 8 + $clog2(DELAY_MIN + 1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REACT
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tick_q, tick_d;
    logic [6:0]         lfsr_q, lfsr_d;
    logic               cmd_delay_q, cmd_delay_d;
    logic               button_q, button_d;
    logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
    logic [REACT_W-1:0] rcnt_q, rcnt_d;
    logic               jump_q, jump_d;
    logic               time_out_q, time_out_d;
    logic               react_valid_q, react_valid_d;
    logic [REACT_W-1:0] react_time_q, react_time_d;
    logic               cmd_rise_c;
    logic               btn_rise_c;

    assign cmd_rise_c = cmd_delay & ~cmd_delay_q;
    assign btn_rise_c = button & ~button_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = '0;
        tick_d        = 1'b0;
        lfsr_d        = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        cmd_delay_d   = cmd_delay;
        button_d      = button;
        dcnt_d        = dcnt_q;
        rcnt_d        = rcnt_q;
        jump_d        = jump_q;
        time_out_d    = 1'b0;
        react_valid_d = 1'b0;
        react_time_d  = react_time_q;

        // tick is registered, so it is raised when the counter is about to hold TICK_N-1
        if (cmd_seq) begin
            cnt_d = (cnt_q == CNT_W'(TICK_N - 1)) ? '0 : cnt_q + CNT_W'(1);
        end
        tick_d = cmd_seq && (cnt_d == CNT_W'(TICK_N - 1));

        case (state_q)
            IDLE: begin
                if (cmd_rise_c) begin
                    dcnt_d  = DCNT_W'(DELAY_MIN) + DCNT_W'(lfsr_q);
                    jump_d  = 1'b0;
                    state_d = DELAY;
                end
            end
            DELAY: begin
                dcnt_d = dcnt_q - DCNT_W'(1);
                if (btn_rise_c) begin
                    jump_d = 1'b1;
                end
                // a press in the time_out cycle itself still counts as a jump
                if (dcnt_q == DCNT_W'(1)) begin
                    rcnt_d  = '0;
                    state_d = jump_d ? IDLE : REACT;
                end
            end
            REACT: begin
                if (rcnt_q != '1) begin
                    rcnt_d = rcnt_q + REACT_W'(1);
                end
                if (btn_rise_c) begin
                    react_time_d  = rcnt_q;
                    react_valid_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        time_out_d = (state_d == DELAY) && (dcnt_d == DCNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            tick_q        <= 1'b0;
            lfsr_q        <= LFSR_SEED;
            cmd_delay_q   <= 1'b0;
            button_q      <= 1'b0;
            dcnt_q        <= '0;
            rcnt_q        <= '0;
            jump_q        <= 1'b0;
            time_out_q    <= 1'b0;
            react_valid_q <= 1'b0;
            react_time_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tick_q        <= tick_d;
            lfsr_q        <= lfsr_d;
            cmd_delay_q   <= cmd_delay_d;
            button_q      <= button_d;
            dcnt_q        <= dcnt_d;
            rcnt_q        <= rcnt_d;
            jump_q        <= jump_d;
            time_out_q    <= time_out_d;
            react_valid_q <= react_valid_d;
            react_time_q  <= react_time_d;
        end
    end

    assign tick        = tick_q;
    assign time_out    = time_out_q;
    assign jump_start  = jump_q;
    assign react_valid = react_valid_q;
    assign react_time  = react_time_q;

endmodule

// File: tb/tb_f1_start_ctrl.sv
// Bench for f1_start_ctrl: tick table, directed delay/reaction/jump/reset runs,
// then random stimulus against an event-level reference model.
module tb_f1_start_ctrl;

    localparam int unsigned TN   = 4;
    localparam int unsigned DMIN = 8;
    localparam logic [6:0]  SEED = 7'h01;
    localparam int PH_IDLE  = 0;
    localparam int PH_DELAY = 1;
    localparam int PH_REACT = 2;

    logic clk = 1'b0;
    logic rst, cmd_seq, cmd_delay, button;
    logic tick_a, to_a, js_a, rv_a;
    logic [15:0] rt_a;
    logic tick_b, to_b, js_b, rv_b;
    logic [3:0] rt_b;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [6:0] lf [127];

    // model state
    int m_run, m_phase, m_to, m_rstart, m_rt, m_cyc;
    bit m_js, m_prev_d, m_prev_b;
    bit e_tick, e_to, e_rv;

    always #5 clk = ~clk;

    f1_start_ctrl #(.TICK_N(TN), .DELAY_MIN(DMIN), .LFSR_SEED(SEED), .REACT_W(16)) dut_a (
        .clk(clk), .rst(rst), .cmd_seq(cmd_seq), .cmd_delay(cmd_delay), .button(button),
        .tick(tick_a), .time_out(to_a), .jump_start(js_a), .react_valid(rv_a), .react_time(rt_a)
    );

    f1_start_ctrl #(.TICK_N(TN), .DELAY_MIN(DMIN), .LFSR_SEED(SEED), .REACT_W(4)) dut_b (
        .clk(clk), .rst(rst), .cmd_seq(cmd_seq), .cmd_delay(cmd_delay), .button(button),
        .tick(tick_b), .time_out(to_b), .jump_start(js_b), .react_valid(rv_b), .react_time(rt_b)
    );

    typedef struct {
        logic seq;
        logic exp_tick;
    } tvec_t;
    tvec_t tv [28];

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic next_cycle();
        logic was_rst;
        was_rst = rst;
        @(negedge clk);
        cyc = was_rst ? 0 : cyc + 1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cmd_seq = 1'b0; cmd_delay = 1'b0; button = 1'b0;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_tick"}, int'(tick_a), 0);
        chk({tag, "_to"}, int'(to_a), 0);
        chk({tag, "_js"}, int'(js_a), 0);
        chk({tag, "_rv"}, int'(rv_a), 0);
        chk({tag, "_rt_a"}, int'(rt_a), 0);
        chk({tag, "_rt_b"}, int'(rt_b), 0);
    endtask

    task automatic model_reset();
        m_run = 0; m_phase = PH_IDLE; m_to = 0; m_rstart = 0; m_rt = 0; m_cyc = 0;
        m_js = 0; m_prev_d = 0; m_prev_b = 0;
        e_tick = 0; e_to = 0; e_rv = 0;
    endtask

    // predicts outputs for the next cycle from this cycle's inputs
    task automatic model_step(input bit r, input bit s, input bit d, input bit b);
        bit rise_d, rise_b;
        if (r) begin
            model_reset();
            return;
        end
        rise_d = d & ~m_prev_d;
        rise_b = b & ~m_prev_b;
        m_run  = s ? m_run + 1 : 0;
        e_tick = s && ((m_run % TN) == TN - 1);
        e_to = 0;
        e_rv = 0;
        case (m_phase)
            PH_IDLE: begin
                if (rise_d) begin
                    m_to    = m_cyc + int'(DMIN) + int'(lf[m_cyc % 127]);
                    m_js    = 0;
                    m_phase = PH_DELAY;
                    e_to    = (m_cyc + 1 == m_to);
                end
            end
            PH_DELAY: begin
                if (rise_b) m_js = 1;
                if (m_cyc == m_to) begin
                    m_phase  = m_js ? PH_IDLE : PH_REACT;
                    m_rstart = m_cyc + 1;
                end else begin
                    e_to = (m_cyc + 1 == m_to);
                end
            end
            default: begin
                if (rise_b) begin
                    m_rt    = m_cyc - m_rstart;
                    e_rv    = 1;
                    m_phase = PH_IDLE;
                end
            end
        endcase
        m_prev_d = d;
        m_prev_b = b;
        m_cyc++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t_load, to_at, c1, to1;
        bit r, s, d, b;

        lf[0] = SEED;
        for (int i = 1; i < 127; i++) lf[i] = {lf[i-1][5:0], lf[i-1][6] ^ lf[i-1][5]};
        for (int i = 0; i < 28; i++) begin
            tv[i].seq      = (i < 20) || (i >= 23);
            tv[i].exp_tick = (i == 3 || i == 7 || i == 11 || i == 15 || i == 19 || i == 26);
        end

        rst = 1'b1; cmd_seq = 1'b0; cmd_delay = 1'b0; button = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();
        chk_zero("reset");

        // tick period table
        for (int i = 0; i < 28; i++) begin
            chk("tick", int'(tick_a), int'(tv[i].exp_tick));
            chk("tick_b", int'(tick_b), int'(tv[i].exp_tick));
            cmd_seq = tv[i].seq;
            next_cycle();
        end

        // deterministic delay: load in cycle 1 with lfsr=2, time_out 10 cycles later
        do_reset();
        chk_zero("reset2");
        next_cycle();
        cmd_delay = 1'b1;
        while (cyc < 48) begin
            next_cycle();
            chk("delay_to", int'(to_a), int'(cyc == 11));
            chk("delay_js", int'(js_a), 0);
        end
        button = 1'b1;
        next_cycle();
        chk("react_rv", int'(rv_a), 1);
        chk("react_rt", int'(rt_a), 36);
        chk("react_rt_sat", int'(rt_b), 15);
        chk("react_js", int'(js_a), 0);
        cmd_delay = 1'b0;
        next_cycle();
        chk("react_rv_once", int'(rv_a), 0);

        // jump start: press 3 cycles after the load
        cmd_delay = 1'b1;
        button = 1'b0;
        t_load = cyc;
        to_at = t_load + int'(DMIN) + int'(lf[t_load % 127]);
        while (cyc < to_at + 3) begin
            next_cycle();
            chk("jump_to", int'(to_a), int'(cyc == to_at));
            chk("jump_rv", int'(rv_a), 0);
            chk("jump_rt", int'(rt_a), 36);
            chk("jump_js", int'(js_a), int'(cyc >= t_load + 4));
            if (cyc == t_load + 3) button = 1'b1;
        end
        cmd_delay = 1'b0;
        button = 1'b0;
        next_cycle();
        chk("jump_hold", int'(js_a), 1);

        // new run clears jump; second cmd_rise in DELAY must not restart; saturation
        cmd_delay = 1'b1;
        c1 = cyc;
        to1 = c1 + int'(DMIN) + int'(lf[c1 % 127]);
        next_cycle();
        chk("jump_clear", int'(js_a), 0);
        cmd_delay = 1'b0;
        next_cycle();
        cmd_delay = 1'b1;
        while (cyc < to1 + 41) begin
            next_cycle();
            chk("ign_to", int'(to_a), int'(cyc == to1));
        end
        button = 1'b1;
        next_cycle();
        chk("sat_rv", int'(rv_a), 1);
        chk("sat_rt", int'(rt_a), 40);
        chk("sat_rt_b", int'(rt_b), 15);

        // mid-run reset during DELAY
        button = 1'b0;
        cmd_delay = 1'b0;
        next_cycle();
        cmd_delay = 1'b1;
        repeat (3) next_cycle();
        rst = 1'b1;
        cmd_delay = 1'b0;
        next_cycle();
        rst = 1'b0;
        chk_zero("midrst");
        next_cycle();
        cmd_delay = 1'b1;
        while (cyc < 20) begin
            next_cycle();
            chk("midrst_to", int'(to_a), int'(cyc == 11));
            chk("midrst_rt", int'(rt_a), 0);
        end

        // random stimulus against the reference model
        do_reset();
        model_reset();
        s = 0; d = 0; b = 0;
        for (int k = 0; k < 4000; k++) begin
            chk("rnd_tick", int'(tick_a), int'(e_tick));
            chk("rnd_to", int'(to_a), int'(e_to));
            chk("rnd_js", int'(js_a), int'(m_js));
            chk("rnd_rv", int'(rv_a), int'(e_rv));
            chk("rnd_rt_a", int'(rt_a), sat(m_rt, 65535));
            chk("rnd_rt_b", int'(rt_b), sat(m_rt, 15));
            r = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 29) == 0) s = ~s;
            if ($urandom_range(0, 14) == 0) d = ~d;
            if ($urandom_range(0, 11) == 0) b = ~b;
            rst = r; cmd_seq = s; cmd_delay = d; button = b;
            model_step(r, s, d, b);
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/f1_start_ctrl.md
# f1_start_ctrl

Sequencing controller for the F1 start-light state machine. It generates the light-advance `tick` while the light FSM reports `cmd_seq`. When `cmd_delay` is raised, it runs a pseudo-random lights-out delay and returns a one-cycle `time_out`. It then measures the driver's reaction time from lights-out to the button press and flags jump starts. It sits between the board button/clock and the light FSM, and its results go to the display logic.

## Interface
- `TICK_N`, 24: clock cycles per `tick` period; must be ≥ 2.
- `DELAY_MIN`, 16: fixed part of the lights-out delay, in cycles.
- `LFSR_SEED`, 7'h01: LFSR value loaded on reset; must be non-zero.
- `REACT_W`, 16: width of the reaction counter.
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `cmd_seq`  in  1: light FSM is in its sequencing phase.
- `cmd_delay`  in  1: light FSM requests a lights-out delay.
- `button`  in  1: driver button; already synchronised and debounced.
- `tick`  out  1: one-cycle pulse that advances the lights.
- `time_out`  out  1: one-cycle pulse at the end of the delay; drives the FSM `timeOut` input.
- `jump_start`  out  1: level output; button pressed before lights-out in the current run.
- `react_valid`  out  1: one-cycle pulse when `react_time` updates.
- `react_time`  out  REACT_W: last measured reaction, in cycles.

## Operation
- All outputs and state are registered. On reset: `tick`, `time_out`, `jump_start` and `react_valid` are 0. `react_time` is 0, the tick counter is 0, `lfsr` = `LFSR_SEED`, and the FSM enters `IDLE`.
- Tick generator:
  - While `cmd_seq`=1, the counter counts 0..TICK_N-1 and wraps to 0.
  - `tick`=1 during the cycle in which the counter holds TICK_N-1.
  - While `cmd_seq`=0, the counter is held at 0 and `tick`=0.
- LFSR:
  - 7 bits, free-running, advances every cycle: `lfsr` <= {`lfsr`[5:0], `lfsr`[6]^`lfsr`[5]}.
  - It never reaches 0.
- Edge detect:
  - `cmd_rise` = `cmd_delay` & ~`cmd_delay_q`.
  - `btn_rise` = `button` & ~`button_q`.
  - Both registers reset to 0. Button levels are ignored; only rising edges count.
- FSM states: `IDLE`, `DELAY`, `REACT`.
  - `IDLE`, on `cmd_rise`:
    - Load `dcnt` = DELAY_MIN + `lfsr` (current value). The sum is 8 bits wide plus the width needed for DELAY_MIN.
    - Clear `jump_start`, go to `DELAY`.
    - `btn_rise` in `IDLE` is ignored.
  - `DELAY`:
    - `dcnt` decrements once per cycle.
    - When `dcnt`=1, `time_out`=1 for that cycle.
    - Next state is `REACT` with `rcnt` cleared to 0 if `jump_start`=0; otherwise `IDLE`.
    - `btn_rise` in `DELAY` (including the load cycle's next-edge capture) sets `jump_start`=1.
    - `jump_start` holds until the next `cmd_rise` or reset.
  - `REACT`:
    - `rcnt` increments once per cycle and saturates at all-ones. It does not wrap.
    - On `btn_rise`: `react_time` <= `rcnt`, `react_valid`=1 for one cycle, go to `IDLE`.
- `cmd_rise` outside `IDLE` is ignored. The running delay or measurement is not restarted.
- After a jump start, `time_out` still fires, so the light FSM always returns to its start state. No `react_valid` is produced for that run, and `react_time` keeps its old value.

## Timing
- `tick` latency:
  - When `cmd_seq` rises before edge k, the first `tick` is high during cycle k+TICK_N-1.
  - Subsequent ticks follow every TICK_N cycles.
- Delay:
  - Suppose `cmd_delay` rises and is sampled at edge t, with L = DELAY_MIN + `lfsr`(t).
  - `time_out` is high for exactly one cycle, L cycles after `dcnt` is loaded.
  - The delay is therefore between DELAY_MIN+1 and DELAY_MIN+127 cycles.
- Reaction:
  - `rcnt`=0 in the first `REACT` cycle, the cycle after `time_out`.
  - A button edge in that cycle reports `react_time`=0.
  - `react_valid` and the new `react_time` appear on the edge after `btn_rise` is seen.
- `btn_rise` coinciding with `time_out`: counts as a jump only if it occurs while in `DELAY`. The `time_out` cycle is still in `DELAY`, so the press is a jump start.
- Reset mid-run (any state) returns every output to its reset value on the next edge. A pending `time_out` is lost.

## Test plan
- Tick period:
  - Stimulus: TICK_N=4, `cmd_seq`=1 from the first post-reset cycle for 20 cycles, then 0.
  - Required: `tick` high in cycles 3, 7, 11, 15, 19 only. No tick after `cmd_seq` drops. The counter restarts from 0.
- Deterministic delay:
  - Stimulus: DELAY_MIN=8, seed 7'h01; `cmd_delay` rises so that it is sampled when `lfsr`=7'h02 (the second post-reset cycle).
  - Required: `time_out` is a single pulse exactly 10 cycles after the load.
- Reaction measure:
  - Stimulus: as the delay test, then a button rising edge 37 cycles after `time_out`.
  - Required: `react_valid` pulses once, `react_time`=36, `jump_start`=0, FSM back in `IDLE`.
- Jump start:
  - Stimulus: button edge 3 cycles after the delay load.
  - Required: `jump_start`=1 and held; `time_out` still pulses at the scheduled cycle; no `react_valid`; `react_time` unchanged. The next `cmd_rise` clears `jump_start`.
- Saturation and ignore rules:
  - Stimulus: REACT_W=4, no button for 40 cycles in `REACT`, then a press. Also a second `cmd_rise` issued during `DELAY`.
  - Required: `react_time`=15. The delay is not restarted by the second `cmd_rise`.
- Mid-run reset:
  - Stimulus: assert `rst` for one cycle while in `DELAY`.
  - Required: all outputs 0, no `time_out`, `lfsr` = seed, and the next `cmd_rise` starts a clean run.
